stage_id: RTL and testbench

STAGE_ID -- requirements
Module: stage_id

---
 rtl/riscv_pkg.sv | 147 ++++++++++++++
 rtl/imm_gen.sv | 27 ++
 rtl/stage_id.sv | 155 +++++++++++++++
 tb/tb_stage_id.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode constants, decode control types and the shared decode helpers.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       Branch;
    logic       Jump;
    logic       AluSrc;
    logic [3:0] AluOp;
  } ctrl_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  use_rs1;
    logic  use_rs2;
    logic  illegal;
  } dec_t;

  function automatic imm_type_t imm_type_of(input logic [6:0] opc);
    imm_type_t t;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: t = IMM_I;
      OPC_STORE:                                                t = IMM_S;
      OPC_BRANCH:                                               t = IMM_B;
      OPC_LUI, OPC_AUIPC:                                       t = IMM_U;
      OPC_JAL:                                                  t = IMM_J;
      default:                                                  t = IMM_NONE;
    endcase
    return t;
  endfunction

  // alt selects SUB/SRA; callers only raise it where the encoding allows.
  function automatic logic [3:0] alu_of(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t       d;
    logic [2:0] f3;
    logic       f7b5;
    d    = '0;
    f3   = inst[14:12];
    f7b5 = inst[30];
    case (inst[6:0])
      OPC_LUI: begin
        d.ctrl.RegWrite = 1'b1;
        d.ctrl.AluSrc   = 1'b1;
        d.ctrl.AluOp    = ALU_PASSB;
      end
      OPC_AUIPC: begin
        d.ctrl.RegWrite = 1'b1;
        d.ctrl.AluSrc   = 1'b1;
      end
      OPC_JAL: begin
        d.ctrl.RegWrite = 1'b1;
        d.ctrl.Jump     = 1'b1;
      end
      OPC_JALR: begin
        d.ctrl.RegWrite = 1'b1;
        d.ctrl.Jump     = 1'b1;
        d.ctrl.AluSrc   = 1'b1;
        d.use_rs1       = 1'b1;
      end
      OPC_BRANCH: begin
        d.ctrl.Branch = 1'b1;
        d.ctrl.AluOp  = ALU_SUB;
        d.use_rs1     = 1'b1;
        d.use_rs2     = 1'b1;
      end
      OPC_LOAD: begin
        d.ctrl.RegWrite = 1'b1;
        d.ctrl.MemRead  = 1'b1;
        d.ctrl.AluSrc   = 1'b1;
        d.use_rs1       = 1'b1;
      end
      OPC_STORE: begin
        d.ctrl.MemWrite = 1'b1;
        d.ctrl.AluSrc   = 1'b1;
        d.use_rs1       = 1'b1;
        d.use_rs2       = 1'b1;
      end
      OPC_OP_IMM: begin
        d.ctrl.RegWrite = 1'b1;
        d.ctrl.AluSrc   = 1'b1;
        d.ctrl.AluOp    = alu_of(f3, (f3 == 3'b101) & f7b5);
        d.use_rs1       = 1'b1;
      end
      OPC_OP: begin
        d.ctrl.RegWrite = 1'b1;
        d.ctrl.AluOp    = alu_of(f3, f7b5);
        d.use_rs1       = 1'b1;
        d.use_rs2       = 1'b1;
      end
      // fence and system instructions pass through as no-ops at this stage
      OPC_MISC_MEM, OPC_SYSTEM: d.illegal = 1'b0;
      default:                  d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - sign-extended RV32I immediate selected by opcode; R-type and unknown give 0.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           inst,
  output logic [DATA_WIDTH-1:0] imm
);

  logic signed [31:0] raw;

  always_comb begin
    raw = '0;
    case (imm_type_of(inst[6:0]))
      IMM_I:   raw = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   raw = {inst[31:12], 12'b0};
      IMM_J:   raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: raw = '0;
    endcase
  end

  assign imm = DATA_WIDTH'(raw);

endmodule

// File: rtl/stage_id.sv
// rtl/stage_id.sv - RV32I decode stage with load-use stall and flush.
// STAGE_ID_FORWARD_EN selects Ex/Wb operand forwarding; otherwise any pending write to a source stalls.
module stage_id
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_InstValid,
  output logic                  o_InstReady,
  input  logic [31:0]           i_Inst,
  input  logic [PC_WIDTH-1:0]   i_PC,
  output logic [ADDR_WIDTH-1:0] o_RdAddrA,
  output logic [ADDR_WIDTH-1:0] o_RdAddrB,
  input  logic [DATA_WIDTH-1:0] i_RdDataA,
  input  logic [DATA_WIDTH-1:0] i_RdDataB,
  input  logic [ADDR_WIDTH-1:0] i_ExWrAddr,
  input  logic                  i_ExWrEnable,
  input  logic                  i_ExIsLoad,
  input  logic [DATA_WIDTH-1:0] i_ExWrData,
  input  logic [ADDR_WIDTH-1:0] i_WbWrAddr,
  input  logic                  i_WbWrEnable,
  input  logic [DATA_WIDTH-1:0] i_WbWrData,
  input  logic                  i_Flush,
  output logic                  o_ExValid,
  input  logic                  i_ExReady,
  output logic [DATA_WIDTH-1:0] o_DataA,
  output logic [DATA_WIDTH-1:0] o_DataB,
  output logic [DATA_WIDTH-1:0] o_Imm,
  output logic [PC_WIDTH-1:0]   o_PC,
  output logic [ADDR_WIDTH-1:0] o_Rd,
  output ctrl_t                 o_Ctrl,
  output logic                  o_Illegal
);

  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [ADDR_WIDTH-1:0] rd;
  dec_t                  dec;
  ctrl_t                 ctrl_d;
  logic [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic                  hazard;
  logic                  advance;
  logic                  fire;

  assign rs1 = ADDR_WIDTH'(i_Inst[19:15]);
  assign rs2 = ADDR_WIDTH'(i_Inst[24:20]);
  assign rd  = ADDR_WIDTH'(i_Inst[11:7]);
  assign dec = decode(i_Inst);

  assign o_RdAddrA = rs1;
  assign o_RdAddrB = rs2;

  imm_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_imm_gen (
    .inst(i_Inst),
    .imm (imm)
  );

  always_comb begin
    ctrl_d = dec.ctrl;
    if (rd == '0) ctrl_d.RegWrite = 1'b0;
  end

`ifdef STAGE_ID_FORWARD_EN
  function automatic logic [DATA_WIDTH-1:0] operand(
    input logic [ADDR_WIDTH-1:0] idx,
    input logic [DATA_WIDTH-1:0] rf_data,
    input logic                  ex_en,
    input logic                  ex_load,
    input logic [ADDR_WIDTH-1:0] ex_addr,
    input logic [DATA_WIDTH-1:0] ex_data,
    input logic                  wb_en,
    input logic [ADDR_WIDTH-1:0] wb_addr,
    input logic [DATA_WIDTH-1:0] wb_data
  );
    logic [DATA_WIDTH-1:0] v;
    if (idx == '0)                               v = '0;
    else if (ex_en && !ex_load && ex_addr == idx) v = ex_data;
    else if (wb_en && wb_addr == idx)             v = wb_data;
    else                                          v = rf_data;
    return v;
  endfunction

  // a load in Ex has no data yet, so only that case stalls
  always_comb begin
    hazard = i_ExIsLoad & i_ExWrEnable & (i_ExWrAddr != '0) &
             ((dec.use_rs1 & (i_ExWrAddr == rs1)) | (dec.use_rs2 & (i_ExWrAddr == rs2)));
    data_a = operand(rs1, i_RdDataA, i_ExWrEnable, i_ExIsLoad, i_ExWrAddr, i_ExWrData,
                     i_WbWrEnable, i_WbWrAddr, i_WbWrData);
    data_b = operand(rs2, i_RdDataB, i_ExWrEnable, i_ExIsLoad, i_ExWrAddr, i_ExWrData,
                     i_WbWrEnable, i_WbWrAddr, i_WbWrData);
  end
`else
  function automatic logic pending(
    input logic [ADDR_WIDTH-1:0] idx,
    input logic                  ex_en,
    input logic [ADDR_WIDTH-1:0] ex_addr,
    input logic                  wb_en,
    input logic [ADDR_WIDTH-1:0] wb_addr
  );
    return (idx != '0) && ((ex_en && ex_addr == idx) || (wb_en && wb_addr == idx));
  endfunction

  logic unused_ok;
  assign unused_ok = ^{i_ExIsLoad, i_ExWrData, i_WbWrData};

  always_comb begin
    hazard = (dec.use_rs1 & pending(rs1, i_ExWrEnable, i_ExWrAddr, i_WbWrEnable, i_WbWrAddr)) |
             (dec.use_rs2 & pending(rs2, i_ExWrEnable, i_ExWrAddr, i_WbWrEnable, i_WbWrAddr));
    data_a = (rs1 == '0) ? '0 : i_RdDataA;
    data_b = (rs2 == '0) ? '0 : i_RdDataB;
  end
`endif

  assign advance     = ~o_ExValid | i_ExReady;
  assign o_InstReady = advance & ~hazard;
  assign fire        = i_InstValid & o_InstReady;

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      o_ExValid <= 1'b0;
      o_Illegal <= 1'b0;
      o_Ctrl    <= '0;
      o_DataA   <= '0;
      o_DataB   <= '0;
      o_Imm     <= '0;
      o_PC      <= '0;
      o_Rd      <= '0;
    end else if (i_Flush) begin
      o_ExValid <= 1'b0;
      o_Illegal <= 1'b0;
    end else if (fire) begin
      o_ExValid <= 1'b1;
      o_Illegal <= dec.illegal;
      o_Ctrl    <= ctrl_d;
      o_DataA   <= data_a;
      o_DataB   <= data_b;
      o_Imm     <= imm;
      o_PC      <= i_PC;
      o_Rd      <= rd;
    end else if (advance) begin
      // bubble: payload is left in place, only the valid flags drop
      o_ExValid <= 1'b0;
      o_Illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stage_id.sv
// tb/tb_stage_id.sv - directed-vector bench for stage_id (either STAGE_ID_FORWARD_EN build).
module tb_stage_id;
  import riscv_pkg::*;

  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic        i_InstValid;
  logic        o_InstReady;
  logic [31:0] i_Inst;
  logic [31:0] i_PC;
  logic [4:0]  o_RdAddrA;
  logic [4:0]  o_RdAddrB;
  logic [31:0] i_RdDataA;
  logic [31:0] i_RdDataB;
  logic [4:0]  i_ExWrAddr;
  logic        i_ExWrEnable;
  logic        i_ExIsLoad;
  logic [31:0] i_ExWrData;
  logic [4:0]  i_WbWrAddr;
  logic        i_WbWrEnable;
  logic [31:0] i_WbWrData;
  logic        i_Flush;
  logic        o_ExValid;
  logic        i_ExReady;
  logic [31:0] o_DataA;
  logic [31:0] o_DataB;
  logic [31:0] o_Imm;
  logic [31:0] o_PC;
  logic [4:0]  o_Rd;
  ctrl_t       o_Ctrl;
  logic        o_Illegal;

  int n_total = 0;
  int n_bad   = 0;

  stage_id dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_InstValid (i_InstValid),
    .o_InstReady (o_InstReady),
    .i_Inst      (i_Inst),
    .i_PC        (i_PC),
    .o_RdAddrA   (o_RdAddrA),
    .o_RdAddrB   (o_RdAddrB),
    .i_RdDataA   (i_RdDataA),
    .i_RdDataB   (i_RdDataB),
    .i_ExWrAddr  (i_ExWrAddr),
    .i_ExWrEnable(i_ExWrEnable),
    .i_ExIsLoad  (i_ExIsLoad),
    .i_ExWrData  (i_ExWrData),
    .i_WbWrAddr  (i_WbWrAddr),
    .i_WbWrEnable(i_WbWrEnable),
    .i_WbWrData  (i_WbWrData),
    .i_Flush     (i_Flush),
    .o_ExValid   (o_ExValid),
    .i_ExReady   (i_ExReady),
    .o_DataA     (o_DataA),
    .o_DataB     (o_DataB),
    .o_Imm       (o_Imm),
    .o_PC        (o_PC),
    .o_Rd        (o_Rd),
    .o_Ctrl      (o_Ctrl),
    .o_Illegal   (o_Illegal)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_Clock);
    #1;
  endtask

  logic [31:0] t_inst [4] = '{32'hFE20AE23, 32'hFE208CE3, 32'hFFDFF06F, 32'h00000FFF};
  logic [31:0] t_imm  [4] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000};
  logic [9:0]  t_ctrl [4] = '{10'h090, 10'h041, 10'h020, 10'h000};
  logic [4:0]  t_rd   [4] = '{5'h1C, 5'h19, 5'h00, 5'h1F};
  logic        t_ill  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    i_Reset = 1'b0;  i_InstValid = 1'b0; i_Inst = '0; i_PC = '0;
    i_RdDataA = '0;  i_RdDataB = '0;
    i_ExWrAddr = '0; i_ExWrEnable = 1'b0; i_ExIsLoad = 1'b0; i_ExWrData = '0;
    i_WbWrAddr = '0; i_WbWrEnable = 1'b0; i_WbWrData = '0;
    i_Flush = 1'b0;  i_ExReady = 1'b1;
    tick; tick;
    check("rst_valid", o_ExValid, 0);
    check("rst_ctrl", o_Ctrl, 0);
    check("rst_pc", o_PC, 0);
    i_Reset = 1'b1;
    #1;
    check("rst_ready", o_InstReady, 1);

    // addi x1,x0,5 at 0x100
    i_Inst = 32'h00500093; i_PC = 32'h100; i_InstValid = 1'b1;
    #1;
    check("addi_rda", o_RdAddrA, 0);
    check("addi_rdb", o_RdAddrB, 5);
    tick;
    check("addi_valid", o_ExValid, 1);
    check("addi_imm", o_Imm, 5);
    check("addi_rd", o_Rd, 1);
    check("addi_pc", o_PC, 32'h100);
    check("addi_ctrl", o_Ctrl, 10'h210);
    check("addi_ill", o_Illegal, 0);

    // load-use: lw x2 in Ex, add x3,x2,x2 in decode
    i_Inst = 32'h002101B3; i_PC = 32'h104;
    i_ExIsLoad = 1'b1; i_ExWrEnable = 1'b1; i_ExWrAddr = 5'd2;
    #1;
    check("lu_rda", o_RdAddrA, 2);
    check("lu_ready", o_InstReady, 0);
    tick;
    check("lu_bubble", o_ExValid, 0);
    i_ExIsLoad = 1'b0; i_ExWrEnable = 1'b0;
    i_RdDataA = 32'h11; i_RdDataB = 32'h22;
    #1;
    check("lu_ready2", o_InstReady, 1);
    tick;
    check("add_valid", o_ExValid, 1);
    check("add_rd", o_Rd, 3);
    check("add_a", o_DataA, 32'h11);
    check("add_b", o_DataB, 32'h22);
    check("add_imm", o_Imm, 0);
    check("add_pc", o_PC, 32'h104);
    check("add_ctrl", o_Ctrl, 10'h200);

    // addi x6,x5,1 with x5 pending in both Ex and Wb
    i_Inst = 32'h00128313; i_PC = 32'h108; i_RdDataA = '0;
    i_ExWrEnable = 1'b1; i_ExWrAddr = 5'd5; i_ExWrData = 32'hDEAD;
    i_WbWrEnable = 1'b1; i_WbWrAddr = 5'd5; i_WbWrData = 32'hBEEF;
    #1;
`ifdef STAGE_ID_FORWARD_EN
    check("fwd_ready", o_InstReady, 1);
    tick;
    check("fwd_ex", o_DataA, 32'hDEAD);
    i_ExWrEnable = 1'b0;
    tick;
    check("fwd_wb", o_DataA, 32'hBEEF);
`else
    check("nofwd_ex_ready", o_InstReady, 0);
    i_ExWrEnable = 1'b0;
    #1;
    check("nofwd_wb_ready", o_InstReady, 0);
`endif
    i_ExWrEnable = 1'b0; i_WbWrEnable = 1'b0; i_RdDataA = 32'h1234;
    tick;
    check("rf_a", o_DataA, 32'h1234);
    check("rf_imm", o_Imm, 1);
    check("rf_rd", o_Rd, 6);

    // stall three cycles while lui waits
    i_ExReady = 1'b0; i_Inst = 32'h123453B7; i_PC = 32'h10C; i_RdDataA = 32'h5555;
    #1;
    check("stall_ready", o_InstReady, 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check("stall_valid", o_ExValid, 1);
      check("stall_pc", o_PC, 32'h108);
      check("stall_a", o_DataA, 32'h1234);
      check("stall_rd", o_Rd, 6);
      check("stall_ready", o_InstReady, 0);
    end
    i_ExReady = 1'b1;
    tick;
    check("lui_imm", o_Imm, 32'h12345000);
    check("lui_rd", o_Rd, 7);
    check("lui_ctrl", o_Ctrl, 10'h21A);
    check("lui_pc", o_PC, 32'h10C);

    // sw, beq, jal x0, illegal opcode
    for (int k = 0; k < 4; k++) begin
      i_Inst = t_inst[k]; i_PC = 32'h200 + 32'(k * 4);
      tick;
      check("tbl_valid", o_ExValid, 1);
      check("tbl_imm", o_Imm, t_imm[k]);
      check("tbl_ctrl", o_Ctrl, t_ctrl[k]);
      check("tbl_rd", o_Rd, t_rd[k]);
      check("tbl_ill", o_Illegal, t_ill[k]);
    end

    // flush, then flush during stall
    i_Flush = 1'b1; i_Inst = 32'h00128313; i_PC = 32'h300;
    tick;
    check("flush_valid", o_ExValid, 0);
    check("flush_ill", o_Illegal, 0);
    i_Flush = 1'b0;
    tick;
    check("post_flush", o_ExValid, 1);
    i_ExReady = 1'b0; i_Flush = 1'b1;
    tick;
    check("flush_stall", o_ExValid, 0);
    i_Flush = 1'b0; i_ExReady = 1'b1;

    // async reset while stalled
    tick;
    i_ExReady = 1'b0;
    tick;
    check("pre_rst_valid", o_ExValid, 1);
    #1;
    i_Reset = 1'b0;
    #1;
    check("arst_valid", o_ExValid, 0);
    check("arst_ill", o_Illegal, 0);
    check("arst_ctrl", o_Ctrl, 0);
    check("arst_a", o_DataA, 0);
    check("arst_b", o_DataB, 0);
    check("arst_imm", o_Imm, 0);
    check("arst_pc", o_PC, 0);
    check("arst_rd", o_Rd, 0);
    i_InstValid = 1'b0;
    tick;
    i_Reset = 1'b1; i_ExReady = 1'b1;
    #1;
    check("rel_ready", o_InstReady, 1);
    tick;
    check("rel_valid", o_ExValid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
